// File: rtl/n_term_loopback_pipe.sv
// n_term_loopback_pipe: north-edge termination tile.
// Loops north-travelling wires back south through a per-group configurable
// delay of 0..2 register stages, with a freeze control and a saturating
// input-activity counter. Clock and frame signals are forwarded unchanged.
module n_term_loopback_pipe #(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int CfgFrame        = 0,
    parameter int W1              = 4,
    parameter int W2              = 8,
    parameter int W4              = 16
) (
    input  logic                       UserCLK,
    input  logic                       Reset,
    input  logic [W1-1:0]              N1END,
    input  logic [W2-1:0]              N2MID,
    input  logic [W2-1:0]              N2END,
    input  logic [W4-1:0]              N4END,
    output logic [W1-1:0]              S1BEG,
    output logic [W2-1:0]              S2BEG,
    output logic [W2-1:0]              S2BEGb,
    output logic [W4-1:0]              S4BEG,
    input  logic [FrameBitsPerRow-1:0] FrameData,
    output logic [FrameBitsPerRow-1:0] FrameData_O,
    input  logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic [MaxFramesPerCol-1:0] FrameStrobe_O,
    output logic                       UserCLKo,
    output logic [15:0]                ActCount
);

    // Total number of loopback wires watched by the activity counter.
    localparam int NW = W1 + 2*W2 + W4;

    // Configuration register and decoded fields.
    logic [7:0] cfg_r;
    logic [1:0] d1_s;
    logic [1:0] d2_s;
    logic [1:0] d4_s;
    logic       frz_s;
    logic       clr_s;

    assign d1_s  = cfg_r[1:0];
    assign d2_s  = cfg_r[3:2];
    assign d4_s  = cfg_r[5:4];
    assign frz_s = cfg_r[6];
    assign clr_s = cfg_r[7];

    // Both double-hop buses share the D2 delay, so they are handled as one group.
    logic [2*W2-1:0] n2_s;
    assign n2_s = {N2END, N2MID};

    // Shift-register stages per group.
    logic [W1-1:0]   st1_g1_r, st2_g1_r;
    logic [2*W2-1:0] st1_g2_r, st2_g2_r;
    logic [W4-1:0]   st1_g4_r, st2_g4_r;

    // A group stops shifting only when frozen and not in bypass; a bypassed
    // group keeps tracking its input so a later delay change sees fresh history.
    logic en_g1_s, en_g2_s, en_g4_s;
    assign en_g1_s = !(frz_s && (d1_s != 2'd0));
    assign en_g2_s = !(frz_s && (d2_s != 2'd0));
    assign en_g4_s = !(frz_s && (d4_s != 2'd0));

    // Activity tracking.
    logic [NW-1:0] in_s;
    logic [NW-1:0] prev_r;
    logic          chg_s;
    logic [15:0]   act_r;

    assign in_s  = {N4END, N2END, N2MID, N1END};
    assign chg_s = (in_s != prev_r);

    // Capture the low frame-data byte as configuration while our strobe is high.
    always_ff @(posedge UserCLK or posedge Reset) begin
        if (Reset) begin
            cfg_r <= 8'h00;
        end else if (FrameStrobe[CfgFrame]) begin
            cfg_r <= FrameData[7:0];
        end else begin
            cfg_r <= cfg_r;
        end
    end

    // Single-hop group two-stage shift register, held while frozen.
    always_ff @(posedge UserCLK or posedge Reset) begin
        if (Reset) begin
            st1_g1_r <= '0;
            st2_g1_r <= '0;
        end else if (en_g1_s) begin
            st1_g1_r <= N1END;
            st2_g1_r <= st1_g1_r;
        end else begin
            st1_g1_r <= st1_g1_r;
            st2_g1_r <= st2_g1_r;
        end
    end

    // Double-hop group two-stage shift register, held while frozen.
    always_ff @(posedge UserCLK or posedge Reset) begin
        if (Reset) begin
            st1_g2_r <= '0;
            st2_g2_r <= '0;
        end else if (en_g2_s) begin
            st1_g2_r <= n2_s;
            st2_g2_r <= st1_g2_r;
        end else begin
            st1_g2_r <= st1_g2_r;
            st2_g2_r <= st2_g2_r;
        end
    end

    // Quad-hop group two-stage shift register, held while frozen.
    always_ff @(posedge UserCLK or posedge Reset) begin
        if (Reset) begin
            st1_g4_r <= '0;
            st2_g4_r <= '0;
        end else if (en_g4_s) begin
            st1_g4_r <= N4END;
            st2_g4_r <= st1_g4_r;
        end else begin
            st1_g4_r <= st1_g4_r;
            st2_g4_r <= st2_g4_r;
        end
    end

    // Output tap selection; code 3 deliberately shares the two-stage tap.
    logic [W1-1:0]   s1_s;
    logic [2*W2-1:0] s2_s;
    logic [W4-1:0]   s4_s;

    // Pick each group's output from input / stage 1 / stage 2.
    always_comb begin
        s1_s = N1END;
        s2_s = n2_s;
        s4_s = N4END;
        case (d1_s)
            2'd0:    s1_s = N1END;
            2'd1:    s1_s = st1_g1_r;
            default: s1_s = st2_g1_r;
        endcase
        case (d2_s)
            2'd0:    s2_s = n2_s;
            2'd1:    s2_s = st1_g2_r;
            default: s2_s = st2_g2_r;
        endcase
        case (d4_s)
            2'd0:    s4_s = N4END;
            2'd1:    s4_s = st1_g4_r;
            default: s4_s = st2_g4_r;
        endcase
    end

    assign S1BEG  = s1_s;
    assign S2BEG  = s2_s[W2-1:0];
    assign S2BEGb = s2_s[2*W2-1:W2];
    assign S4BEG  = s4_s;

    // Remember last-edge inputs so any wire toggle can be detected.
    always_ff @(posedge UserCLK or posedge Reset) begin
        if (Reset) begin
            prev_r <= '0;
        end else begin
            prev_r <= in_s;
        end
    end

    // Saturating activity counter; clear wins over counting, freeze is ignored.
    always_ff @(posedge UserCLK or posedge Reset) begin
        if (Reset) begin
            act_r <= 16'h0000;
        end else if (clr_s) begin
            act_r <= 16'h0000;
        end else if (chg_s && (act_r != 16'hFFFF)) begin
            act_r <= act_r + 16'h0001;
        end else begin
            act_r <= act_r;
        end
    end

    assign ActCount = act_r;

    // Fabric passthroughs: pure wires.
    assign FrameData_O   = FrameData;
    assign FrameStrobe_O = FrameStrobe;
    assign UserCLKo      = UserCLK;

endmodule

// File: tb/tb_n_term_loopback_pipe.sv
// Directed self-checking bench for n_term_loopback_pipe.
module tb_n_term_loopback_pipe;

    logic        clk;
    logic        rst;
    logic [3:0]  n1;
    logic [7:0]  n2mid;
    logic [7:0]  n2end;
    logic [15:0] n4;
    logic [3:0]  s1;
    logic [7:0]  s2;
    logic [7:0]  s2b;
    logic [15:0] s4;
    logic [31:0] fdata;
    logic [31:0] fdata_o;
    logic [19:0] fstrobe;
    logic [19:0] fstrobe_o;
    logic        clko;
    logic [15:0] act;

    int n_cmp;
    int n_err;

    n_term_loopback_pipe dut (
        .UserCLK       (clk),
        .Reset         (rst),
        .N1END         (n1),
        .N2MID         (n2mid),
        .N2END         (n2end),
        .N4END         (n4),
        .S1BEG         (s1),
        .S2BEG         (s2),
        .S2BEGb        (s2b),
        .S4BEG         (s4),
        .FrameData     (fdata),
        .FrameData_O   (fdata_o),
        .FrameStrobe   (fstrobe),
        .FrameStrobe_O (fstrobe_o),
        .UserCLKo      (clko),
        .ActCount      (act)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load a config byte with one strobe pulse; upper frame bits are junk.
    task automatic load_cfg(input logic [7:0] c);
        fdata   = {24'hABCDEF, c};
        fstrobe = 20'h00001;
        tick();
        fstrobe = 20'h00000;
        fdata   = 32'h5A5A_0000;
    endtask

    task automatic chk_pass(input string tag);
        chk({tag, "_fdata"}, fdata_o, fdata);
        chk({tag, "_fstrobe"}, {12'h000, fstrobe_o}, {12'h000, fstrobe});
        chk({tag, "_clk"}, {31'h0, clko}, {31'h0, clk});
    endtask

    // Walking one on N4END: output must be the value driven two steps earlier.
    task automatic walk(input string tag, input logic [15:0] hist);
        logic [15:0] one;
        logic [15:0] expv;
        one = 16'h0001;
        for (int i = 0; i < 6; i++) begin
            n4 = one << i;
            #1;
            expv = (i < 2) ? hist : (one << (i - 2));
            chk(tag, {16'h0, s4}, {16'h0, expv});
            tick();
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rst     = 1'b1;
        n1      = 4'h0;
        n2mid   = 8'h00;
        n2end   = 8'h00;
        n4      = 16'h0000;
        fdata   = 32'h0000_0000;
        fstrobe = 20'h00000;

        // Reset: bypass and zero count.
        #2;
        n4 = 16'hA5A5;
        #1;
        chk("rst_bypass_s4", {16'h0, s4}, 32'h0000_A5A5);
        chk("rst_act", {16'h0, act}, 32'h0);
        tick();
        tick();
        chk("rst_act_held", {16'h0, act}, 32'h0);
        chk_pass("rst");

        n4 = 16'h0000;
        #1;
        rst = 1'b0;
        tick();
        chk("idle_act", {16'h0, act}, 32'h0);

        // cfg 0x24: D1=0, D2=1, D4=2.
        load_cfg(8'h24);
        n2mid = 8'h3C;
        n4    = 16'h1234;
        n1    = 4'h5;
        #1;
        chk("d1_comb", {28'h0, s1}, 32'h5);
        chk("d2_pre", {24'h0, s2}, 32'h0);
        chk("d4_pre", {16'h0, s4}, 32'h0);
        tick();
        chk("d2_lat1", {24'h0, s2}, 32'h3C);
        chk("d4_lat1", {16'h0, s4}, 32'h0);
        tick();
        chk("d4_lat2", {16'h0, s4}, 32'h1234);
        chk("act_one", {16'h0, act}, 32'h1);

        // D4=3 and D4=2 give the same two-cycle latency.
        load_cfg(8'h30);
        walk("d4_code3", 16'h1234);
        load_cfg(8'h20);
        walk("d4_code2", 16'h0020);

        // Freeze with D2=1.
        load_cfg(8'h04);
        n2end = 8'h11;
        tick();
        tick();
        chk("frz_pre", {24'h0, s2b}, 32'h11);
        load_cfg(8'h44);
        n4 = 16'h7E7E;
        for (int k = 0; k < 5; k++) begin
            n2end = (k % 2 == 0) ? 8'hEE : 8'h11;
            #1;
            chk("frz_hold", {24'h0, s2b}, 32'h11);
            chk("frz_d4_bypass", {16'h0, s4}, 32'h7E7E);
            tick();
        end
        chk("frz_hold_end", {24'h0, s2b}, 32'h11);
        n2end = 8'h22;
        load_cfg(8'h04);
        chk("unfrz_first", {24'h0, s2b}, 32'h11);
        tick();
        chk("unfrz_follow", {24'h0, s2b}, 32'h22);
        n2end = 8'h33;
        #1;
        chk("unfrz_lat_pre", {24'h0, s2b}, 32'h22);
        tick();
        chk("unfrz_lat", {24'h0, s2b}, 32'h33);

        // Clear, then saturate the activity counter.
        load_cfg(8'h80);
        tick();
        chk("clr_zero", {16'h0, act}, 32'h0);
        load_cfg(8'h00);
        chk("clr_still0", {16'h0, act}, 32'h0);
        for (int i = 0; i < 70000; i++) begin
            n1[0] = ~n1[0];
            tick();
        end
        chk("sat", {16'h0, act}, 32'hFFFF);
        for (int i = 0; i < 4; i++) begin
            n1[0] = ~n1[0];
            tick();
        end
        chk("sat_hold", {16'h0, act}, 32'hFFFF);
        load_cfg(8'h80);
        chk("clr_capture_edge", {16'h0, act}, 32'hFFFF);
        tick();
        chk("clr_after", {16'h0, act}, 32'h0);
        load_cfg(8'h00);
        tick();
        tick();
        chk("static_zero", {16'h0, act}, 32'h0);

        // Async reset mid-stream with D4=2.
        load_cfg(8'h20);
        n4 = 16'h0F0F;
        tick();
        n4 = 16'hF0F0;
        tick();
        n4 = 16'hBEEF;
        #1;
        chk("pre_rst_d4", {16'h0, s4}, 32'h0F0F);
        rst = 1'b1;
        #1;
        chk("async_rst_s4", {16'h0, s4}, 32'hBEEF);
        chk("async_rst_act", {16'h0, act}, 32'h0);
        chk_pass("async_rst");
        #1;
        rst = 1'b0;
        n4  = 16'hCAFE;
        #1;
        chk("post_rst_bypass", {16'h0, s4}, 32'hCAFE);
        tick();
        chk("post_rst_bypass2", {16'h0, s4}, 32'hCAFE);
        chk("post_rst_s2b", {24'h0, s2b}, {24'h0, n2end});
        fdata   = 32'hDEAD_BEEF;
        fstrobe = 20'hA5A50;
        #1;
        chk_pass("final");
        fstrobe = 20'h00000;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
